// File: rtl/ads_sample_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : ads_sample_packetizer
// Purpose  : Buffers ADC conversion results and frames them into
//            checksummed byte packets for the host link.
// Revision : 1.0 - initial release
// ============================================================================
module ads_sample_packetizer #(
    parameter int         DATA_WIDTH        = 24,
    parameter int         FIFO_DEPTH        = 16,
    parameter int         SAMPLES_PER_FRAME = 8,
    parameter logic [7:0] SYNC_BYTE         = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         sample_in,
    input  logic                          sample_valid,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          tx_last,
    input  logic                          clear_overflow,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_BPS = DATA_WIDTH / 8;
    localparam int c_AW  = $clog2(FIFO_DEPTH);
    localparam int c_LW  = c_AW + 1;
    localparam int c_BW  = (c_BPS > 1) ? $clog2(c_BPS) : 1;
    localparam int c_SW  = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SYNC  = 3'd1;
    localparam logic [2:0] c_ST_SEQ   = 3'd2;
    localparam logic [2:0] c_ST_DATA  = 3'd3;
    localparam logic [2:0] c_ST_CKSUM = 3'd4;

    localparam logic [c_BW-1:0] c_LAST_BYTE   = c_BW'(c_BPS - 1);
    localparam logic [c_SW-1:0] c_LAST_SAMPLE = c_SW'(SAMPLES_PER_FRAME - 1);
    localparam logic [c_LW-1:0] c_FULL_LEVEL  = c_LW'(FIFO_DEPTH);
    localparam logic [c_LW-1:0] c_FRAME_LEVEL = c_LW'(SAMPLES_PER_FRAME);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_LW-1:0]       r_level;
    logic [2:0]            r_state;
    logic [7:0]            r_seq;
    logic [7:0]            r_cksum;
    logic [c_BW-1:0]       r_byte_idx;
    logic [c_SW-1:0]       r_samp_idx;
    logic                  r_overflow;
    logic [15:0]           r_drop_count;

    logic                  w_full;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_accept;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;
    logic [7:0]            w_data_byte;

    // Fullness uses the registered level, so a same-cycle pop cannot rescue a sample.
    assign w_full   = (r_level == c_FULL_LEVEL);
    assign w_push   = sample_valid && !w_full;
    assign w_drop   = sample_valid && w_full;
    assign w_accept = tx_valid && tx_ready;
    assign w_pop    = w_accept && (r_state == c_ST_DATA) && (r_byte_idx == c_LAST_BYTE);
    assign w_head   = r_mem[r_rd_ptr];

    always_comb begin
        w_data_byte = 8'h00;
        for (int i = 0; i < c_BPS; i++) begin
            if (r_byte_idx == c_BW'(c_BPS - 1 - i)) begin
                w_data_byte = w_head[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LW'(1);
            end
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 16'h0000;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_overflow) begin
                r_drop_count <= 16'h0001;
            end else if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'h0001;
            end
        end else if (clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_seq      <= 8'h00;
            r_cksum    <= 8'h00;
            r_byte_idx <= '0;
            r_samp_idx <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_level >= c_FRAME_LEVEL) begin
                        r_state <= c_ST_SYNC;
                        r_cksum <= 8'h00;
                    end
                end
                c_ST_SYNC: begin
                    if (w_accept) begin
                        r_state <= c_ST_SEQ;
                    end
                end
                c_ST_SEQ: begin
                    if (w_accept) begin
                        r_cksum    <= r_cksum ^ r_seq;
                        r_state    <= c_ST_DATA;
                        r_byte_idx <= '0;
                        r_samp_idx <= '0;
                    end
                end
                c_ST_DATA: begin
                    if (w_accept) begin
                        r_cksum <= r_cksum ^ w_data_byte;
                        if (r_byte_idx == c_LAST_BYTE) begin
                            r_byte_idx <= '0;
                            if (r_samp_idx == c_LAST_SAMPLE) begin
                                r_state <= c_ST_CKSUM;
                            end else begin
                                r_samp_idx <= r_samp_idx + c_SW'(1);
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + c_BW'(1);
                        end
                    end
                end
                c_ST_CKSUM: begin
                    if (w_accept) begin
                        r_seq   <= r_seq + 8'h01;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode purely from registered state, so they hold while stalled.
    always_comb begin
        tx_data = 8'h00;
        tx_last = 1'b0;
        case (r_state)
            c_ST_SYNC:  tx_data = SYNC_BYTE;
            c_ST_SEQ:   tx_data = r_seq;
            c_ST_DATA:  tx_data = w_data_byte;
            c_ST_CKSUM: begin
                tx_data = r_cksum;
                tx_last = 1'b1;
            end
            default:    tx_data = 8'h00;
        endcase
    end

    assign tx_valid   = (r_state != c_ST_IDLE);
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign fifo_level = r_level;

endmodule
`default_nettype wire
